// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-ported memory between instruction fetch and the MEM stage.
// Data requests win unless fetch has lost FETCH_STARVE_MAX arbitrations in a row.
module mem_port_arbiter #(
  parameter int MEM_LATENCY      = 2,
  parameter int FETCH_STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_ack,
  output logic [31:0] f_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] LAT_INIT   = 4'(MEM_LATENCY - 1);
  localparam logic [3:0] STARVE_LIM = 4'(FETCH_STARVE_MAX);

  state_t      state, state_nx;
  logic        owner_data, owner_data_nx;
  logic [3:0]  lat_cnt, lat_cnt_nx;
  logic [3:0]  starve_cnt, starve_cnt_nx;
  logic        mem_en_nx, mem_we_nx, f_ack_nx, d_ack_nx;
  logic [31:0] mem_addr_nx, mem_wdata_nx, f_rdata_nx, d_rdata_nx;
  logic [3:0]  mem_be_nx;
  logic        grant_d, grant_f;

  // Data loses only when fetch is both waiting and has hit its starvation limit.
  assign grant_d = d_req && ((starve_cnt < STARVE_LIM) || !f_req);
  assign grant_f = f_req && !grant_d;

  assign stall_if  = f_req & ~f_ack;
  assign stall_mem = d_req & ~d_ack;
  assign busy      = (state != IDLE);

  always_comb begin
    state_nx      = state;
    owner_data_nx = owner_data;
    lat_cnt_nx    = lat_cnt;
    starve_cnt_nx = starve_cnt;
    mem_en_nx     = mem_en;
    mem_we_nx     = mem_we;
    mem_addr_nx   = mem_addr;
    mem_wdata_nx  = mem_wdata;
    mem_be_nx     = mem_be;
    f_rdata_nx    = f_rdata;
    d_rdata_nx    = d_rdata;
    f_ack_nx      = 1'b0;
    d_ack_nx      = 1'b0;

    case (state)
      IDLE: begin
        if (grant_d || grant_f) begin
          owner_data_nx = grant_d;
          mem_en_nx     = 1'b1;
          mem_we_nx     = grant_d && d_we;
          mem_addr_nx   = grant_d ? d_addr : f_addr;
          mem_wdata_nx  = grant_d ? d_wdata : 32'h0;
          mem_be_nx     = (grant_d && d_we) ? d_be : 4'hF;
          lat_cnt_nx    = LAT_INIT;
          state_nx      = ACCESS;
          if (grant_d && f_req)
            starve_cnt_nx = (starve_cnt == 4'hF) ? 4'hF : starve_cnt + 4'd1;
          else
            starve_cnt_nx = 4'd0;
        end
      end
      ACCESS: begin
        if (lat_cnt == 4'd0) begin
          if (owner_data) begin
            d_ack_nx = 1'b1;
            if (!mem_we)
              d_rdata_nx = mem_rdata;
          end else begin
            f_ack_nx   = 1'b1;
            f_rdata_nx = mem_rdata;
          end
          mem_en_nx = 1'b0;
          mem_we_nx = 1'b0;
          state_nx  = DONE;
        end else begin
          lat_cnt_nx = lat_cnt - 4'd1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner_data <= 1'b0;
      lat_cnt    <= 4'd0;
      starve_cnt <= 4'd0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
      mem_be     <= 4'h0;
      f_ack      <= 1'b0;
      d_ack      <= 1'b0;
      f_rdata    <= 32'h0;
      d_rdata    <= 32'h0;
    end else begin
      state      <= state_nx;
      owner_data <= owner_data_nx;
      lat_cnt    <= lat_cnt_nx;
      starve_cnt <= starve_cnt_nx;
      mem_en     <= mem_en_nx;
      mem_we     <= mem_we_nx;
      mem_addr   <= mem_addr_nx;
      mem_wdata  <= mem_wdata_nx;
      mem_be     <= mem_be_nx;
      f_ack      <= f_ack_nx;
      d_ack      <= d_ack_nx;
      f_rdata    <= f_rdata_nx;
      d_rdata    <= d_rdata_nx;
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, fixed-latency memory between the instruction-fetch stage (read-only) and the MEM stage (load/store driven by en_mem_read/en_mem_write out of the EX/MEM register).
- Sequences each access and returns read data.
- Generates per-requester stall signals for the pipeline.
- Data port has priority; a starvation counter guarantees forward progress for fetch.

Parameters:
- MEM_LATENCY, 2, cycles from mem_en asserted to mem_rdata valid (legal range 1..15).
- FETCH_STARVE_MAX, 3, consecutive arbitrations fetch may lose before it is forced to win (legal range 1..15).

Ports:
- clk  in  1  Rising-edge clock; the design's only clock.
- rst  in  1  Reset: synchronous, active-high.
- f_req  in  1  Fetch read request; held until f_ack.
- f_addr  in  32  Fetch word address.
- f_ack  out  1  One-cycle pulse; f_rdata valid.
- f_rdata  out  32  Fetch read data, registered.
- d_req  in  1  MEM-stage request (en_mem_read | en_mem_write); held until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  Data address.
- d_wdata  in  32  Store data.
- d_be  in  4  Store byte enables.
- d_ack  out  1  One-cycle pulse; d_rdata valid (loads), store complete.
- d_rdata  out  32  Load data, registered.
- stall_if  out  1  f_req & ~f_ack (combinational).
- stall_mem  out  1  d_req & ~d_ack (combinational).
- mem_en  out  1  Memory access active; held for the whole access.
- mem_we  out  1  Memory write.
- mem_addr  out  32  Memory address.
- mem_wdata  out  32  Memory write data.
- mem_be  out  4  Memory byte enables; 4'hF for reads.
- mem_rdata  in  32  Memory read data; valid in the last ACCESS cycle.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset:
  - State goes to IDLE.
  - All registered outputs are 0: mem_en, mem_we, mem_addr, mem_wdata, mem_be, f_ack, d_ack, f_rdata, d_rdata, busy.
  - Starvation counter and latency counter are 0.
- Reset mid-access: abandons the access immediately. No ack is generated. The requester keeps req high and is re-served after reset. A store that was in flight may already have been committed; this is accepted.
- FSM IDLE:
  - Samples requests only in this state.
  - Grants data if d_req and starve_cnt < FETCH_STARVE_MAX.
  - Otherwise grants fetch if f_req.
  - Otherwise grants data if d_req.
  - No request: stay in IDLE.
  - On a grant: latch owner, addr, we, wdata, be (fetch: we=0, be=4'hF) into the mem_* registers. Set mem_en=1 and lat_cnt=MEM_LATENCY-1. Go to ACCESS.
- Starvation counter:
  - Increments (saturating at 15) when data wins while f_req is high.
  - Clears when fetch wins, or when arbitration happens with f_req low.
- FSM ACCESS:
  - mem_* held stable.
  - lat_cnt decrements each cycle.
  - At lat_cnt==0: capture mem_rdata into the owner's rdata register, pulse the owner's ack for the next cycle, drop mem_en/mem_we. Go to DONE.
- FSM DONE:
  - The owner's ack=1 for exactly this cycle. The other rdata register is unchanged.
  - Unconditionally go to IDLE.
  - Requesters must deassert req in the cycle after ack unless they issue a new request.
- Latency:
  - Request seen in IDLE at cycle 0 gives mem_en high in cycles 1..MEM_LATENCY.
  - Ack is high in cycle MEM_LATENCY+1.
  - Back-to-back accesses cost MEM_LATENCY+2 cycles each (one IDLE arbitration cycle).
- Simultaneous requests in IDLE: resolved by the priority rule above. The loser's stall stays high; it never receives an ack it did not win.
- Address and data inputs are don't-care outside the IDLE sampling cycle.
- Stores: d_rdata is not updated.
- Request changing while owner: ignored. Only one outstanding access exists at a time.

Test Plan:
- Reset during ACCESS of a fetch (MEM_LATENCY=2): assert rst at cycle 2 → next cycle busy=0, mem_en=0, no f_ack. After rst low, the held f_req is re-served with f_ack 3 cycles after the IDLE sample.
- Single fetch (f_addr=0x100, memory returns 0xDEADBEEF): mem_en high in cycles 1-2 with mem_addr=0x100 and mem_be=4'hF. f_ack=1 in cycle 3 with f_rdata=0xDEADBEEF. stall_if high in cycles 0-2.
- Store (d_addr=0x2000, d_wdata=0x12345678, d_be=4'b0011): mem_we=1, mem_be=4'b0011, mem_wdata=0x12345678 held for 2 cycles. d_ack in cycle 3. d_rdata stays 0.
- Simultaneous f_req and d_req (load 0x40 → 0xA5A5A5A5): data is served first, d_ack in cycle 3. Fetch is granted in the next IDLE (cycle 4), f_ack in cycle 7. stall_if high throughout cycles 0-6.
- Starvation with FETCH_STARVE_MAX=3: f_req held, d_req re-asserted after every ack → data wins 3 arbitrations, fetch wins the 4th, then starve_cnt reads 0.
- MEM_LATENCY=1 corner: mem_en high for exactly 1 cycle and ack in cycle 2. With both requesters holding req, the pattern alternates per the starvation rule; each access takes 3 cycles.
